branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 115 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational; updates from the resolve stage commit on the
// rising clock edge. Optional statistics counters are compiled in when the
// macro BRANCH_PREDICTOR_STATS_EN is defined.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_taken,
  input  logic              update_pred_taken,
  input  logic [ADDR_W-1:0] update_pred_target,
  output logic              mispredict
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  // Reset leaves counters weakly not-taken; allocation starts weakly taken.
  localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_MAX   = '1;

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [CTR_W-1:0]  r_ctr    [ENTRIES];

  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [IDX_W-1:0]  w_up_idx;
  logic [TAG_W-1:0]  w_up_tag;
  logic              w_up_hit;
  logic              w_unused_pc_lsbs;

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign w_up_idx = update_pc[IDX_W+1:2];
  assign w_up_tag = update_pc[ADDR_W-1:IDX_W+2];
  assign w_unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Combinational lookup: reads pre-update contents in the same cycle.
  always_comb begin
    pred_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    pred_taken  = pred_hit && r_ctr[w_lk_idx][CTR_W-1];
    pred_target = pred_taken ? r_target[w_lk_idx] : (lookup_pc + ADDR_W'(4));
  end

  // Resolve-stage comparison against the prediction carried down the pipe.
  always_comb begin
    w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    mispredict = update_valid &&
                 ((update_taken != update_pred_taken) ||
                  (update_taken && (update_pred_target != update_target)));
  end

  // Table update: train on hit, allocate on taken miss; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RST;
      end
    end else if (update_valid) begin
      if (w_up_hit) begin
        if (update_taken) begin
          r_target[w_up_idx] <= update_target;
          if (r_ctr[w_up_idx] != CTR_MAX) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 1'b1;
        end else if (r_ctr[w_up_idx] != '0) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 1'b1;
        end
      end else if (update_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= update_target;
        r_ctr[w_up_idx]    <= CTR_ALLOC;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] r_stat_updates;
  logic [31:0] r_stat_mispredicts;

  // Free-running event counters, wrapping at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_updates     <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (update_valid) r_stat_updates <= r_stat_updates + 32'd1;
      if (mispredict)   r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_updates     = r_stat_updates;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
